// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state encodings, reset polarity and helpers for the memory bus arbiter
package mem_bus_arbiter_pkg;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int RUN_W = 4;
   localparam logic ARB_RST_ACTIVE = 1'b0;
   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY_IF = 2'd1,
      ARB_BUSY_D  = 2'd2
   } arb_state_e;
   function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v, input logic [RUN_W-1:0] max);
      return (v == max) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch port, data port and memory port signals of the SOPC memory arbiter
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SEL_W  = DATA_W / 8
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [SEL_W-1:0]  d_sel;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [SEL_W-1:0]  mem_sel;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   // slave is the arbiter's view; master is the core plus memory side
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_sel, d_wdata, mem_ack, mem_rdata,
      output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_sel, mem_wdata
   );
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_sel, d_wdata, mem_ack, mem_rdata,
      input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_sel, mem_wdata
   );
endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// mem_bus_arbiter_arb_pick: data-first priority picker with a bounded data run while fetch waits
module mem_bus_arbiter_arb_pick
   import mem_bus_arbiter_pkg::*;
#(
   parameter int MAX_DATA_RUN = 4
) (
   input  logic             cand_if_i,
   input  logic             cand_d_i,
   input  logic [RUN_W-1:0] run_cnt_i,
   output logic             grant_if_o,
   output logic             grant_d_o
);
   logic fetch_due;
   assign fetch_due  = cand_if_i && (run_cnt_i == RUN_W'(MAX_DATA_RUN));
   assign grant_d_o  = cand_d_i && !fetch_due;
   assign grant_if_o = cand_if_i && !grant_d_o;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises CPU fetch and load/store accesses onto one single-port memory
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int SEL_W        = DATA_W / 8,
   parameter int MAX_DATA_RUN = 4
) (
   input logic              clk,
   input logic              rst,
   mem_bus_arbiter_if.slave bus
);
   arb_state_e        state_q, state_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              arb, cand_if, cand_d, grant_if, grant_d;

   // the port being acked this cycle still holds req high, so it is not a candidate
   assign arb     = (state_q == ARB_IDLE) || bus.mem_ack;
   assign cand_if = arb && bus.if_req && (state_q != ARB_BUSY_IF);
   assign cand_d  = arb && bus.d_req && (state_q != ARB_BUSY_D);

   mem_bus_arbiter_arb_pick #(.MAX_DATA_RUN(MAX_DATA_RUN)) u_pick (
      .cand_if_i (cand_if),
      .cand_d_i  (cand_d),
      .run_cnt_i (run_q),
      .grant_if_o(grant_if),
      .grant_d_o (grant_d)
   );

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      we_d    = we_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      wdata_d = wdata_q;
      if (arb) begin
         state_d = grant_d ? ARB_BUSY_D : grant_if ? ARB_BUSY_IF : ARB_IDLE;
         run_d   = (grant_if || !bus.if_req) ? '0 : grant_d ? sat_inc(run_q, RUN_W'(MAX_DATA_RUN)) : run_q;
      end
      if (grant_if || grant_d) begin
         we_d    = grant_d && bus.d_we;
         addr_d  = grant_d ? bus.d_addr : bus.if_addr;
         sel_d   = grant_d ? bus.d_sel : '1;
         wdata_d = grant_d ? bus.d_wdata : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst == ARB_RST_ACTIVE) begin
         state_q <= ARB_IDLE;
         run_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         sel_q   <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.mem_req   = state_q != ARB_IDLE;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_sel   = sel_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_ack    = bus.mem_ack && (state_q == ARB_BUSY_IF);
   assign bus.d_ack     = bus.mem_ack && (state_q == ARB_BUSY_D);
   assign bus.if_rdata  = bus.mem_rdata;
   assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic against a transaction-level arbiter model
module tb_mem_bus_arbiter;
   localparam int MAX = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int errors = 0;
   int m_own = 0;
   int m_run = 0;
   logic m_we = 1'b0;
   logic [31:0] m_addr = '0;
   logic [3:0] m_sel = '0;
   logic [31:0] m_wdata = '0;

   mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) bus ();

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .MAX_DATA_RUN(MAX)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // owner 0 = none, 1 = fetch, 2 = data; evaluated once per clock from the inputs seen at that edge
   task automatic model_edge;
      logic ci, cd;
      if (rst === 1'b0) begin
         m_own = 0; m_run = 0; m_we = 0; m_addr = 0; m_sel = 0; m_wdata = 0;
      end else if (m_own == 0 || bus.mem_ack) begin
         ci = bus.if_req && m_own != 1;
         cd = bus.d_req && m_own != 2;
         if (!bus.if_req) m_run = 0;
         if (ci && (!cd || m_run == MAX)) begin
            m_own = 1; m_run = 0; m_we = 0; m_addr = bus.if_addr; m_sel = 4'hF; m_wdata = 0;
         end else if (cd) begin
            m_own = 2;
            if (bus.if_req && m_run < MAX) m_run++;
            m_we = bus.d_we; m_addr = bus.d_addr; m_sel = bus.d_sel; m_wdata = bus.d_wdata;
         end else m_own = 0;
      end
   endtask

   task automatic tick;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
      bus.d_sel = 0; bus.d_wdata = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
      rst = 0;
      tick(); tick();
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.if_ack, bus.d_ack} !== 72'd0) begin
         errors++;
         $display("FAIL reset_state: got req=%b we=%b addr=%h sel=%h wdata=%h ifack=%b dack=%b, want all 0",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.if_ack, bus.d_ack);
      end
      rst = 1;
   endtask

   task automatic test_single_fetch;
      bus.if_req = 1; bus.if_addr = 32'h0000_0010;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_not_early: mem_req=%b want 0", bus.mem_req); end
      tick();
      bus.mem_ack = 1; bus.mem_rdata = 32'h3401_1100;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_sel, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
         errors++;
         $display("FAIL fetch_issue: req=%b we=%b sel=%h addr=%h want 1 0 f 00000010", bus.mem_req, bus.mem_we, bus.mem_sel, bus.mem_addr);
      end
      checks++;
      if ({bus.if_ack, bus.d_ack, bus.if_rdata} !== {1'b1, 1'b0, 32'h3401_1100}) begin
         errors++;
         $display("FAIL fetch_ack: ifack=%b dack=%b rdata=%h want 1 0 34011100", bus.if_ack, bus.d_ack, bus.if_rdata);
      end
      tick();
      bus.if_req = 0; bus.mem_ack = 0;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fetch_release: mem_req=%b want 0", bus.mem_req); end
   endtask

   task automatic test_simultaneous;
      bus.if_req = 1; bus.if_addr = 32'h40;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'hDEAD_BEEF; bus.d_sel = 4'b0011;
      tick();
      bus.mem_ack = 1;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.d_ack, bus.if_ack} !==
          {1'b1, 1'b1, 32'h20, 4'b0011, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL simul_store_first: req=%b we=%b addr=%h sel=%h wdata=%h dack=%b ifack=%b want 1 1 20 3 deadbeef 1 0",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.d_ack, bus.if_ack);
      end
      tick();
      bus.d_req = 0;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.if_ack} !==
          {1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1}) begin
         errors++;
         $display("FAIL simul_fetch_next: req=%b we=%b addr=%h sel=%h wdata=%h ifack=%b want 1 0 40 f 0 1",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.if_ack);
      end
      tick();
      bus.if_req = 0; bus.mem_ack = 0;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL simul_release: mem_req=%b want 0", bus.mem_req); end
   endtask

   task automatic test_slow_mem;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h80; bus.d_sel = 4'hF; bus.d_wdata = 32'h1234_5678;
      tick();
      bus.if_req = 1; bus.if_addr = 32'h84;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({bus.mem_addr, bus.mem_wdata, bus.if_ack, bus.d_ack} !== {32'h80, 32'h1234_5678, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL slow_hold[%0d]: addr=%h wdata=%h ifack=%b dack=%b want 80 12345678 0 0",
                     i, bus.mem_addr, bus.mem_wdata, bus.if_ack, bus.d_ack);
         end
         tick();
      end
      bus.mem_ack = 1;
      #1;
      checks++;
      if ({bus.d_ack, bus.if_ack} !== 2'b10) begin errors++; $display("FAIL slow_ack: dack=%b ifack=%b want 1 0", bus.d_ack, bus.if_ack); end
      tick();
      bus.d_req = 0;
      #1;
      checks++;
      if ({bus.if_ack, bus.mem_addr} !== {1'b1, 32'h84}) begin
         errors++; $display("FAIL slow_fetch: ifack=%b addr=%h want 1 84", bus.if_ack, bus.mem_addr);
      end
      tick();
      bus.if_req = 0; bus.mem_ack = 0;
      #1;
   endtask

   task automatic test_rearm;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.d_sel = 4'hF;
      bus.if_req = 1; bus.if_addr = 32'h200;
      tick();
      bus.mem_ack = 1;
      #1;
      checks++;
      if (bus.d_ack !== 1'b1) begin errors++; $display("FAIL rearm_dack: dack=%b want 1", bus.d_ack); end
      tick();
      bus.mem_ack = 0;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_addr, bus.mem_we} !== {1'b1, 32'h200, 1'b0}) begin
         errors++; $display("FAIL rearm_fetch_granted: req=%b addr=%h we=%b want 1 200 0", bus.mem_req, bus.mem_addr, bus.mem_we);
      end
      bus.d_req = 0; bus.mem_ack = 1;
      #1;
      checks++;
      if ({bus.if_ack, bus.d_ack} !== 2'b10) begin errors++; $display("FAIL rearm_ifack: ifack=%b dack=%b want 1 0", bus.if_ack, bus.d_ack); end
      tick();
      bus.if_req = 0; bus.mem_ack = 0;
      #1;
      checks++;
      if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rearm_no_regrant: mem_req=%b want 0", bus.mem_req); end
   endtask

   task automatic test_reset_mid;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h300; bus.d_sel = 4'h5; bus.d_wdata = 32'hA5A5_0F0F;
      tick();
      rst = 0;
      tick();
      rst = 1; bus.d_req = 0; bus.mem_ack = 1;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.if_ack, bus.d_ack} !== 72'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: req=%b we=%b addr=%h sel=%h wdata=%h ifack=%b dack=%b want all 0",
                  bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.if_ack, bus.d_ack);
      end
      tick();
      bus.mem_ack = 0;
      #1;
      checks++;
      if ({bus.mem_req, bus.mem_addr} !== 33'd0) begin
         errors++; $display("FAIL reset_mid_stays_idle: req=%b addr=%h want 0 0", bus.mem_req, bus.mem_addr);
      end
   endtask

   // busy=1 keeps both requesters asserted, which also bounds the data run seen by a waiting fetch
   task automatic test_traffic(input int cycles, input int busy);
      logic [71:0] obs, exp;
      logic if_done, d_done;
      int mcnt, lat, d_run;
      if_done = 0; d_done = 0; mcnt = 0; lat = 0; d_run = 0;
      for (int c = 0; c < cycles + 60; c++) begin
         if (if_done) bus.if_req = 0;
         if (d_done) bus.d_req = 0;
         if (c < cycles && !bus.if_req && (busy != 0 || $urandom_range(0, 2) == 0)) begin
            bus.if_req = 1; bus.if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (c < cycles && !bus.d_req && (busy != 0 || $urandom_range(0, 2) == 0)) begin
            bus.d_req = 1; bus.d_we = 1'($urandom); bus.d_addr = $urandom; bus.d_sel = 4'($urandom); bus.d_wdata = $urandom;
         end
         if (c >= cycles && !bus.if_req && !bus.d_req && m_own == 0) break;
         bus.mem_ack = (m_own != 0) ? (mcnt >= lat) : ($urandom_range(0, 7) == 0);
         bus.mem_rdata = $urandom;
         #1;
         obs = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_sel, bus.mem_wdata, bus.if_ack, bus.d_ack};
         exp = {m_own != 0, m_we, m_addr, m_sel, m_wdata, bus.mem_ack && m_own == 1, bus.mem_ack && m_own == 2};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL traffic_cycle %0d: got {req,we,addr,sel,wdata,ifack,dack}=%h want %h", c, obs, exp);
         end
         if (bus.if_ack || bus.d_ack) begin
            checks++;
            if (bus.if_rdata !== bus.mem_rdata || bus.d_rdata !== bus.mem_rdata) begin
               errors++; $display("FAIL traffic_rdata %0d: if=%h d=%h want %h", c, bus.if_rdata, bus.d_rdata, bus.mem_rdata);
            end
         end
         if (bus.mem_ack && m_own == 2 && bus.if_req) begin
            d_run++;
            checks++;
            if (d_run > MAX) begin errors++; $display("FAIL traffic_starve %0d: data run %0d want <= %0d", c, d_run, MAX); end
         end
         if (bus.mem_ack && m_own == 1) d_run = 0;
         if_done = bus.mem_ack && m_own == 1;
         d_done = bus.mem_ack && m_own == 2;
         if (bus.mem_ack && m_own != 0) begin
            mcnt = 0; lat = $urandom_range(0, 3);
         end else if (m_own != 0) mcnt++;
         tick();
      end
      bus.mem_ack = 0;
      #1;
      checks++;
      if (bus.if_req || bus.d_req || m_own != 0) begin
         errors++; $display("FAIL traffic_drain: ifreq=%b dreq=%b owner=%0d want all idle", bus.if_req, bus.d_req, m_own);
      end
      bus.if_req = 0; bus.d_req = 0;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_slow_mem();
      test_rearm();
      test_traffic(400, 0);
      test_traffic(200, 1);
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
